ysyx22041405_wbu: RTL and testbench

//  In-order writeback queue between EXU/LSU and the register file write port (we/waddr/wdata).

---
 rtl/ysyx22041405_wbu_if.sv | 30 +++
 rtl/ysyx22041405_wbu.sv | 151 +++++++++++++++
 tb/tb_ysyx22041405_wbu.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx22041405_wbu_if.sv
// Writeback-queue bus: EXU issue, LSU load return and register-file write port.
// master = producer/consumer side (EXU, LSU, RF); slave = the writeback unit.
interface ysyx22041405_wbu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_wen;
  logic [4:0]       in_rd;
  logic             in_is_load;
  logic [2:0]       in_ldop;
  logic [WIDTH-1:0] in_data;
  logic             lsu_rvalid;
  logic [WIDTH-1:0] lsu_rdata;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  modport master (
    output in_valid, in_wen, in_rd, in_is_load, in_ldop, in_data,
    output lsu_rvalid, lsu_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_wen, in_rd, in_is_load, in_ldop, in_data,
    input  lsu_rvalid, lsu_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ysyx22041405_wbu.sv
// In-order writeback queue with late load-data merge and IDU hazard query.
// Define YSYX22041405_WBU_BYPASS_EN to forward completed results instead of stalling.
module ysyx22041405_wbu #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  ysyx22041405_wbu_if.slave  bus,
  input  logic [4:0]         qry_raddr1,
  input  logic [4:0]         qry_raddr2,
  output logic               qry_busy1,
  output logic               qry_busy2,
  output logic               qry_fwd1,
  output logic               qry_fwd2,
  output logic [WIDTH-1:0]   qry_data1,
  output logic [WIDTH-1:0]   qry_data2,
  output logic [63:0]        retire_cnt,
  output logic               lsu_err
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] e_v, e_wen, e_isld, e_dv;
  logic [4:0]       e_rd   [DEPTH];
  logic [2:0]       e_ldop [DEPTH];
  logic [1:0]       e_off  [DEPTH];
  logic [WIDTH-1:0] e_data [DEPTH];

  logic [AW-1:0] head, tail, lp;
  logic [AW:0]   count;
  logic          lp_found, full, push, pop;

  function automatic logic [WIDTH-1:0] ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [WIDTH-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (op)
      3'b000:  ext = {{(WIDTH-8){b[7]}}, b};
      3'b001:  ext = {{(WIDTH-16){h[15]}}, h};
      3'b100:  ext = {{(WIDTH-8){1'b0}}, b};
      3'b101:  ext = {{(WIDTH-16){1'b0}}, h};
      default: ext = w;
    endcase
  endfunction

  // Scan oldest to youngest so the last hit is the youngest producer.
  function automatic logic [WIDTH+1:0] query(input logic [4:0] ra);
    logic             hit;
    logic [AW-1:0]    idx;
`ifdef YSYX22041405_WBU_BYPASS_EN
    logic             hit_dv;
    logic [WIDTH-1:0] hit_data;
    hit_dv   = 1'b0;
    hit_data = '0;
`endif
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + i[AW-1:0];
      if (e_v[idx] && e_wen[idx] && (e_rd[idx] != 5'd0) && (e_rd[idx] == ra)) begin
        hit = 1'b1;
`ifdef YSYX22041405_WBU_BYPASS_EN
        hit_dv   = e_dv[idx];
        hit_data = e_data[idx];
`endif
      end
    end
`ifdef YSYX22041405_WBU_BYPASS_EN
    query = {hit && !hit_dv, hit && hit_dv, (hit && hit_dv) ? hit_data : '0};
`else
    query = {hit, 1'b0, {WIDTH{1'b0}}};
`endif
  endfunction

  assign full         = (count == (AW+1)'(DEPTH));
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign pop          = e_v[head] && e_dv[head];

  assign bus.rf_we    = pop && e_wen[head] && (e_rd[head] != 5'd0);
  assign bus.rf_waddr = e_rd[head];
  assign bus.rf_wdata = e_data[head];

  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    lp       = '0;
    lp_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + i[AW-1:0];
      if (!lp_found && e_v[idx] && e_isld[idx] && !e_dv[idx]) begin
        lp_found = 1'b1;
        lp       = idx;
      end
    end
  end

  always_comb begin
    {qry_busy1, qry_fwd1, qry_data1} = query(qry_raddr1);
    {qry_busy2, qry_fwd2, qry_data2} = query(qry_raddr2);
  end

  // Push targets tail, pop clears head and the load beat targets lp; these never
  // coincide because lp needs dv=0, head needs dv=1 and tail is free when pushing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_v        <= '0;
      e_wen      <= '0;
      e_isld     <= '0;
      e_dv       <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      retire_cnt <= '0;
      lsu_err    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_rd[i]   <= '0;
        e_ldop[i] <= '0;
        e_off[i]  <= '0;
        e_data[i] <= '0;
      end
    end else begin
      if (pop) begin
        e_v[head]  <= 1'b0;
        head       <= head + 1'b1;
        retire_cnt <= retire_cnt + 64'd1;
      end
      if (push) begin
        e_v[tail]    <= 1'b1;
        e_wen[tail]  <= bus.in_wen;
        e_rd[tail]   <= bus.in_rd;
        e_isld[tail] <= bus.in_is_load;
        e_dv[tail]   <= !bus.in_is_load;
        e_ldop[tail] <= bus.in_ldop;
        e_off[tail]  <= bus.in_data[1:0];
        e_data[tail] <= bus.in_is_load ? '0 : bus.in_data;
        tail         <= tail + 1'b1;
      end
      if (bus.lsu_rvalid) begin
        if (lp_found) begin
          e_dv[lp]   <= 1'b1;
          e_data[lp] <= ext(e_ldop[lp], e_off[lp], bus.lsu_rdata);
        end else begin
          lsu_err <= 1'b1;
        end
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_ysyx22041405_wbu.sv
// Randomised bench for ysyx22041405_wbu against a queue-level reference model.
module tb_ysyx22041405_wbu;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ysyx22041405_wbu_if #(.WIDTH(WIDTH)) bus();
  logic [4:0]  qa1 = '0, qa2 = '0;
  logic        qb1, qb2, qf1, qf2, lerr;
  logic [31:0] qd1, qd2;
  logic [63:0] rcnt;

  ysyx22041405_wbu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .qry_raddr1(qa1), .qry_raddr2(qa2),
    .qry_busy1(qb1), .qry_busy2(qb2), .qry_fwd1(qf1), .qry_fwd2(qf2),
    .qry_data1(qd1), .qry_data2(qd2), .retire_cnt(rcnt), .lsu_err(lerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit        isld;
    bit        dv;
    bit [2:0]  ldop;
    bit [1:0]  off;
    bit [31:0] data;
  } ent_t;

  ent_t            q[$];
  longint unsigned m_cnt = 0;
  bit              m_err = 0;
  int              checks = 0;
  int              failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] m_ext(input bit [2:0] op, input bit [1:0] off, input bit [31:0] raw);
    bit [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * off[1])) & 32'hFFFF;
    case (op)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic void m_query(input bit [4:0] ra, output bit busy, output bit fwd, output bit [31:0] data);
    busy = 0; fwd = 0; data = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wen && q[i].rd != 0 && q[i].rd == ra) begin
`ifdef YSYX22041405_WBU_BYPASS_EN
        if (q[i].dv) begin fwd = 1; data = q[i].data; end
        else busy = 1;
`else
        busy = 1;
`endif
        return;
      end
    end
  endfunction

  function automatic int m_pending();
    for (int i = 0; i < q.size(); i++)
      if (q[i].isld && !q[i].dv) return i;
    return -1;
  endfunction

  // Called at a negedge: drive, check current state, advance model, wait next negedge.
  task automatic step(input bit v, input bit wen, input bit [4:0] rd, input bit ld, input bit [2:0] op,
                      input bit [31:0] d, input bit lv, input bit [31:0] ldat,
                      input bit [4:0] a1, input bit [4:0] a2);
    bit eb, ef, pop, push, we;
    bit [31:0] ed;
    int lp;
    bus.in_valid = v; bus.in_wen = wen; bus.in_rd = rd; bus.in_is_load = ld;
    bus.in_ldop = op; bus.in_data = d; bus.lsu_rvalid = lv; bus.lsu_rdata = ldat;
    qa1 = a1; qa2 = a2;
    #1;
    check("in_ready", bus.in_ready, q.size() < DEPTH);
    pop = (q.size() > 0) && q[0].dv;
    we  = pop && q[0].wen && (q[0].rd != 0);
    check("rf_we", bus.rf_we, we);
    if (we) begin
      check("rf_waddr", bus.rf_waddr, q[0].rd);
      check("rf_wdata", bus.rf_wdata, q[0].data);
    end
    check("retire_cnt", rcnt, m_cnt);
    check("lsu_err", lerr, m_err);
    m_query(a1, eb, ef, ed);
    check("qry_busy1", qb1, eb); check("qry_fwd1", qf1, ef); check("qry_data1", qd1, ed);
    m_query(a2, eb, ef, ed);
    check("qry_busy2", qb2, eb); check("qry_fwd2", qf2, ef); check("qry_data2", qd2, ed);
    push = v && (q.size() < DEPTH);
    if (lv) begin
      lp = m_pending();
      if (lp >= 0) begin
        q[lp].dv   = 1;
        q[lp].data = m_ext(q[lp].ldop, q[lp].off, ldat);
      end else m_err = 1;
    end
    if (pop) begin void'(q.pop_front()); m_cnt++; end
    if (push) q.push_back('{wen, rd, ld, !ld, op, d[1:0], ld ? 32'h0 : d});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input bit [31:0] ldat);
    step(0, 0, 0, 0, 0, 0, 1, ldat, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      if (m_pending() >= 0) beat($urandom);
      else idle(1);
    end
  endtask

  initial begin
    bit [2:0] ops [5];
    bit       v, ld, lv;
    bit [2:0] op;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.in_valid = 0; bus.in_wen = 0; bus.in_rd = 0; bus.in_is_load = 0;
    bus.in_ldop = 0; bus.in_data = 0; bus.lsu_rvalid = 0; bus.lsu_rdata = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    qa1 = 5'd3;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_busy1", qb1, 0);
    check("rst_fwd1", qf1, 0);
    check("rst_data1", qd1, 0);
    check("rst_retire", rcnt, 0);
    check("rst_lsu_err", lerr, 0);
    @(negedge clk);
    rst = 1;

    // ALU write-through latency
    step(1, 1, 5'd5, 0, 0, 32'h1234, 0, 0, 0, 0);
    check("t1_we", bus.rf_we, 1);
    check("t1_waddr", bus.rf_waddr, 5);
    check("t1_wdata", bus.rf_wdata, 32'h1234);
    idle(1);
    check("t1_retire", rcnt, 1);

    // Byte loads, signed and unsigned
    step(1, 1, 5'd7, 1, 3'b000, 32'h1000_0002, 0, 0, 0, 0);
    idle(1);
    beat(32'h0080_0000);
    check("t2_lb", bus.rf_wdata, 32'hFFFF_FF80);
    idle(1);
    step(1, 1, 5'd7, 1, 3'b100, 32'h1000_0002, 0, 0, 0, 0);
    beat(32'h0080_0000);
    check("t2_lbu", bus.rf_wdata, 32'h0000_0080);
    idle(1);

    // ALU behind a pending load must wait
    step(1, 1, 5'd3, 1, 3'b010, 32'h0, 0, 0, 0, 0);
    step(1, 1, 5'd4, 0, 0, 32'hAAAA, 0, 0, 0, 0);
    idle(2);
    check("t3_hold", bus.rf_we, 0);
    beat(32'hDEAD_BEEF);
    check("t3_first", bus.rf_waddr, 3);
    check("t3_first_data", bus.rf_wdata, 32'hDEAD_BEEF);
    idle(1);
    check("t3_second", bus.rf_waddr, 4);
    idle(1);

    // Full queue blocks, one beat frees a slot after the pop
    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 5'(10 + i), 1, (i % 2 == 0) ? 3'b101 : 3'b001, 32'($urandom_range(0, 3)), 0, 0, 0, 0);
    check("t4_full", bus.in_ready, 0);
    step(1, 1, 5'd14, 0, 0, 32'h5555, 0, 0, 0, 0);
    beat(32'h8001_7FFF);
    check("t4_still_full", bus.in_ready, 0);
    idle(1);
    check("t4_freed", bus.in_ready, 1);
    drain();

    // Query hit on a pending ALU result
    step(1, 1, 5'd2, 1, 3'b010, 32'h0, 0, 0, 0, 0);
    step(1, 1, 5'd9, 0, 0, 32'h99, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd2);
`ifdef YSYX22041405_WBU_BYPASS_EN
    check("t6_fwd1", qf1, 1);
    check("t6_data1", qd1, 32'h99);
`else
    check("t6_busy1", qb1, 1);
`endif
    qa1 = 0;
    #1;
    check("t6_x0", qb1, 0);
    @(negedge clk);
    drain();

    // Stray load beat
    beat(32'h1);
    check("t5_err", lerr, 1);
    idle(3);
    check("t5_sticky", lerr, 1);

    // Reset with work in flight
    step(1, 1, 5'd6, 1, 3'b000, 32'h1, 0, 0, 0, 0);
    step(1, 1, 5'd8, 0, 0, 32'h77, 0, 0, 0, 0);
    qa1 = 5'd6;
    #2 rst = 0;
    #1;
    q.delete(); m_cnt = 0; m_err = 0;
    check("mrst_we", bus.rf_we, 0);
    check("mrst_ready", bus.in_ready, 1);
    check("mrst_busy1", qb1, 0);
    check("mrst_retire", rcnt, 0);
    check("mrst_err", lerr, 0);
    @(negedge clk);
    rst = 1;

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      v  = ($urandom_range(0, 1) == 1);
      ld = ($urandom_range(0, 9) < 4);
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : ops[$urandom_range(0, 4)];
      lv = (m_pending() >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      step(v, ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), ld, op, $urandom,
           lv, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
